gpr_file_sb: RTL and testbench
==============================

Name: gpr_file_sb

Overview:
- Parametrised successor to the 8x16 general purpose register file.
- Generalised data width and register count, with two combinational read ports, one write port, an optional r0-hardwired-zero rule and a selectable debug tap register.
- Adds a self-clearing init state machine after reset and a per-register busy scoreboard. Decode uses the scoreboard to stall on pending multi-cycle results (loads, mul).
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = r0 reads 0, ignores writes and reservations, is never busy; 0 = r0 is ordinary.
- OUT_REG, 1, index of the register driven on outrega.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  1 = init clear done, file usable.
- write_en  in  1  write strobe.
- write_dest  in  ADDR_W  write index.
- write_data  in  DATA_W  write value.
- read_addr_1  in  ADDR_W  read port 1 index.
- read_data_1  out  DATA_W  read port 1 data.
- read_addr_2  in  ADDR_W  read port 2 index.
- read_data_2  out  DATA_W  read port 2 data.
- rsv_en  in  1  reserve strobe; marks rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_1  out  1  busy bit of read_addr_1.
- busy_2  out  1  busy bit of read_addr_2.
- outrega  out  DATA_W  contents of r[OUT_REG].

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - state=CLEAR, clr_cnt=0, ready=0, busy vector all 0.
  - read_data_1/2, outrega forced 0; busy_1/2 = 0.
  - Array contents are not reset asynchronously.
- CLEAR state:
  - Each posedge writes 0 to r[clr_cnt] and increments clr_cnt.
  - On the edge that clears index NREGS-1, state goes to RUN and ready=1 at that edge.
  - ready therefore rises exactly NREGS posedges after rst_n deasserts.
  - While ready=0: write_en and rsv_en are ignored, and all data/busy outputs read 0.
- RUN state:
  - Never leaves RUN except through reset.
  - Asserting rst_n low mid-operation restarts CLEAR from index 0.
- Write:
  - Effective write (wr_ok) = ready & write_en & !(ZERO_REG & write_dest==0).
  - On posedge with wr_ok: r[write_dest] <= write_data, and busy[write_dest] <= 0.
- Read:
  - Combinational: read_data_n = r[read_addr_n].
  - If ZERO_REG and read_addr_n==0, read_data_n = 0.
  - Both ports may address the same register.
- Reserve:
  - Effective reserve = ready & rsv_en & !(ZERO_REG & rsv_addr==0).
  - On posedge: busy[rsv_addr] <= 1.
- Simultaneous write and reserve on the same index: reserve wins, so busy stays 1. The new reservation belongs to a later producer. Write data still lands.
- Reserving an already-busy register leaves it busy (no count kept).
- busy_n = busy[read_addr_n], combinational select of the registered vector; 0 for r0 when ZERO_REG.
- outrega = r[OUT_REG], combinational; 0 if ZERO_REG and OUT_REG==0.
- Widths:
  - No arithmetic on data.
  - clr_cnt is ADDR_W bits and wraps only on the final clear edge, where it is unused.

Optional Feature:
- Macro GPR_FILE_SB_BYPASS_EN.
- Defined:
  - If wr_ok and read_addr_n==write_dest, read_data_n = write_data in the same cycle (write-through forwarding).
  - busy_n is forced 0 in that case.
  - outrega also forwards when write_dest==OUT_REG.
- Undefined:
  - Reads return the pre-edge array value.
  - busy_n reflects the stored bit only.

Test Plan:
1. Reset/clear (ADDR_W=3): hold rst_n low 3 cycles, release -> ready=0 for 7 posedges, ready=1 at the 8th. All reads 0, outrega=0.
2. Basic write/read: write r3=0xBEEF, r5=0x1234; read_addr_1=3, read_addr_2=5 -> 0xBEEF and 0x1234 the cycle after the writes. Write r0=0xFFFF with ZERO_REG=1 -> read r0 = 0x0000.
3. Scoreboard: rsv r4 -> busy_1=1 (read_addr_1=4) after the edge. Write r4=0x00AA -> busy_1=0, read_data_1=0x00AA. Reserve and write r4 in the same cycle -> busy stays 1, data=0x00AB.
4. Bypass (macro defined): write_en with r2=0x5555 while read_addr_1=2 -> read_data_1=0x5555 before the edge. Macro undefined -> old value before the edge, 0x5555 after.
5. Reset mid-operation: after writes and reservations in RUN, pulse rst_n low between edges -> ready, busy, and outputs drop to 0 immediately. Clear reruns 8 cycles, then all registers read 0.
6. Parameter sweep (DATA_W=32, ADDR_W=4, ZERO_REG=0, OUT_REG=15): ready after 16 edges. Write r0=0xDEADBEEF reads back. Write r15 -> outrega matches.

Source files
------------

// File: rtl/gpr_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: write port, two read ports,
// reservation port and status outputs.
interface gpr_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              ready;
    logic              write_en;
    logic [ADDR_W-1:0] write_dest;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_addr_1;
    logic [DATA_W-1:0] read_data_1;
    logic [ADDR_W-1:0] read_addr_2;
    logic [DATA_W-1:0] read_data_2;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              busy_1;
    logic              busy_2;
    logic [DATA_W-1:0] outrega;

    modport master (
        input  ready, read_data_1, read_data_2, busy_1, busy_2, outrega,
        output write_en, write_dest, write_data, read_addr_1, read_addr_2,
               rsv_en, rsv_addr
    );

    modport slave (
        output ready, read_data_1, read_data_2, busy_1, busy_2, outrega,
        input  write_en, write_dest, write_data, read_addr_1, read_addr_2,
               rsv_en, rsv_addr
    );
endinterface

// File: rtl/gpr_file_sb.sv
// Parametrised register file with post-reset clear sequencer and per-register busy scoreboard.
// Define GPR_FILE_SB_BYPASS_EN to forward same-cycle writes onto the read ports and outrega.
module gpr_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int OUT_REG  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    gpr_file_sb_if.slave bus
);
    localparam int                NREGS    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_IDX  = ADDR_W'(OUT_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              ready;
    logic              wr_ok;
    logic              rsv_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == LAST_IDX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        ready  = (state == RUN);
        wr_ok  = ready && bus.write_en && !is_zero(bus.write_dest);
        rsv_ok = ready && bus.rsv_en   && !is_zero(bus.rsv_addr);
    end

    // Array has no reset of its own; the clear sequence zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            regs[clr_cnt] <= '0;
        else if (wr_ok)
            regs[bus.write_dest] <= bus.write_data;
    end

    // Reserve is applied after the write-clear so a same-index reservation wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (wr_ok)
                busy[bus.write_dest] <= 1'b0;
            if (rsv_ok)
                busy[bus.rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        bus.ready       = ready;
        bus.read_data_1 = '0;
        bus.read_data_2 = '0;
        bus.busy_1      = 1'b0;
        bus.busy_2      = 1'b0;
        bus.outrega     = '0;
        if (ready) begin
            if (!is_zero(bus.read_addr_1)) begin
                bus.read_data_1 = regs[bus.read_addr_1];
                bus.busy_1      = busy[bus.read_addr_1];
`ifdef GPR_FILE_SB_BYPASS_EN
                if (wr_ok && bus.read_addr_1 == bus.write_dest) begin
                    bus.read_data_1 = bus.write_data;
                    bus.busy_1      = 1'b0;
                end
`endif
            end
            if (!is_zero(bus.read_addr_2)) begin
                bus.read_data_2 = regs[bus.read_addr_2];
                bus.busy_2      = busy[bus.read_addr_2];
`ifdef GPR_FILE_SB_BYPASS_EN
                if (wr_ok && bus.read_addr_2 == bus.write_dest) begin
                    bus.read_data_2 = bus.write_data;
                    bus.busy_2      = 1'b0;
                end
`endif
            end
            if (!is_zero(OUT_IDX)) begin
                bus.outrega = regs[OUT_IDX];
`ifdef GPR_FILE_SB_BYPASS_EN
                if (wr_ok && bus.write_dest == OUT_IDX)
                    bus.outrega = bus.write_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_gpr_file_sb.sv
// Scoreboard bench for gpr_file_sb: default 16x8 instance plus a 32x16, ZERO_REG=0 instance.
module tb_gpr_file_sb;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpr_file_sb_if #(.DATA_W(16), .ADDR_W(3)) bus_a ();
    gpr_file_sb_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

    gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .OUT_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );
    gpr_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .OUT_REG(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef enum int {
        S_RD1_A, S_RD2_A, S_BUSY1_A, S_BUSY2_A, S_OUT_A, S_RDY_A,
        S_RD1_B, S_BUSY1_B, S_OUT_B, S_RDY_B
    } sig_t;

    typedef struct {
        string       tag;
        sig_t        sel;
        logic [63:0] exp;
    } sb_t;

    sb_t sb_q[$];

    function automatic logic [63:0] observe(input sig_t sel);
        case (sel)
            S_RD1_A:   return 64'(bus_a.read_data_1);
            S_RD2_A:   return 64'(bus_a.read_data_2);
            S_BUSY1_A: return 64'(bus_a.busy_1);
            S_BUSY2_A: return 64'(bus_a.busy_2);
            S_OUT_A:   return 64'(bus_a.outrega);
            S_RDY_A:   return 64'(bus_a.ready);
            S_RD1_B:   return 64'(bus_b.read_data_1);
            S_BUSY1_B: return 64'(bus_b.busy_1);
            S_OUT_B:   return 64'(bus_b.outrega);
            S_RDY_B:   return 64'(bus_b.ready);
            default:   return 64'hX;
        endcase
    endfunction

    task automatic sb_push(input string tag, input sig_t sel, input logic [63:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Reference model of the 8-entry instance (r0 hardwired to zero).
    logic [15:0] m_a [8];
    logic [7:0]  mb_a;

    function automatic logic [15:0] exp_rd_a(input logic [2:0] a);
        return (a == 3'd0) ? 16'h0 : m_a[a];
    endfunction

    function automatic logic exp_busy_a(input logic [2:0] a);
        return (a == 3'd0) ? 1'b0 : mb_a[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ports_a(input string tag, input logic [2:0] a1, input logic [2:0] a2);
        bus_a.read_addr_1 = a1;
        bus_a.read_addr_2 = a2;
        sb_push($sformatf("%s.rd1", tag),   S_RD1_A,   64'(exp_rd_a(a1)));
        sb_push($sformatf("%s.rd2", tag),   S_RD2_A,   64'(exp_rd_a(a2)));
        sb_push($sformatf("%s.busy1", tag), S_BUSY1_A, 64'(exp_busy_a(a1)));
        sb_push($sformatf("%s.busy2", tag), S_BUSY2_A, 64'(exp_busy_a(a2)));
        sb_push($sformatf("%s.out", tag),   S_OUT_A,   64'(exp_rd_a(3'd1)));
        #1;
        sb_drain();
    endtask

    task automatic wr_a(input logic [2:0] d, input logic [15:0] v, input logic rsv);
        bus_a.write_en   = 1'b1;
        bus_a.write_dest = d;
        bus_a.write_data = v;
        bus_a.rsv_en     = rsv;
        bus_a.rsv_addr   = d;
        tick();
        bus_a.write_en = 1'b0;
        bus_a.rsv_en   = 1'b0;
        if (d != 3'd0) begin
            m_a[d]  = v;
            mb_a[d] = rsv;
        end
    endtask

    task automatic rsv_a(input logic [2:0] a);
        bus_a.rsv_en   = 1'b1;
        bus_a.rsv_addr = a;
        tick();
        bus_a.rsv_en = 1'b0;
        if (a != 3'd0) mb_a[a] = 1'b1;
    endtask

    task automatic wr_b(input logic [3:0] d, input logic [31:0] v);
        bus_b.write_en   = 1'b1;
        bus_b.write_dest = d;
        bus_b.write_data = v;
        tick();
        bus_b.write_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) m_a[i] = '0;
        mb_a = '0;
        bus_a.write_en = 0; bus_a.write_dest = '0; bus_a.write_data = '0;
        bus_a.read_addr_1 = '0; bus_a.read_addr_2 = '0;
        bus_a.rsv_en = 0; bus_a.rsv_addr = '0;
        bus_b.write_en = 0; bus_b.write_dest = '0; bus_b.write_data = '0;
        bus_b.read_addr_1 = '0; bus_b.read_addr_2 = '0;
        bus_b.rsv_en = 0; bus_b.rsv_addr = '0;

        // Reset held for 3 cycles, then clear sequence timing on both instances
        repeat (3) @(posedge clk);
        #1;
        bus_a.read_addr_1 = 3'd3;
        sb_push("rst.ready", S_RDY_A, 64'd0);
        sb_push("rst.rd1",   S_RD1_A, 64'd0);
        sb_push("rst.out",   S_OUT_A, 64'd0);
        sb_push("rst.b_rdy", S_RDY_B, 64'd0);
        sb_drain();
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            sb_push($sformatf("clr.a_rdy%0d", i), S_RDY_A, 64'(i >= 8));
            sb_push($sformatf("clr.b_rdy%0d", i), S_RDY_B, 64'(i >= 16));
            sb_drain();
        end
        for (int i = 0; i < 8; i++) begin
            check_ports_a($sformatf("zero%0d", i), 3'(i), 3'(7 - i));
            tick();
        end

        // Basic write/read and r0 hardwired zero
        wr_a(3'd3, 16'hBEEF, 1'b0);
        wr_a(3'd5, 16'h1234, 1'b0);
        check_ports_a("wr35", 3'd3, 3'd5);
        wr_a(3'd0, 16'hFFFF, 1'b0);
        check_ports_a("wr0", 3'd0, 3'd3);
        wr_a(3'd1, 16'h0101, 1'b0);
        check_ports_a("wr1", 3'd1, 3'd1);

        // Scoreboard: reserve, clear by write, reserve-wins collision, re-reserve, r0
        rsv_a(3'd4);
        check_ports_a("rsv4", 3'd4, 3'd3);
        wr_a(3'd4, 16'h00AA, 1'b0);
        check_ports_a("wr4", 3'd4, 3'd4);
        wr_a(3'd4, 16'h00AB, 1'b1);
        check_ports_a("wrrsv4", 3'd4, 3'd5);
        rsv_a(3'd4);
        check_ports_a("rersv4", 3'd4, 3'd4);
        rsv_a(3'd0);
        check_ports_a("rsv0", 3'd0, 3'd4);

        // Same-cycle write visibility on a reserved register and on outrega
        rsv_a(3'd2);
        bus_a.read_addr_1 = 3'd2;
        bus_a.write_en    = 1'b1;
        bus_a.write_dest  = 3'd2;
        bus_a.write_data  = 16'h5555;
`ifdef GPR_FILE_SB_BYPASS_EN
        sb_push("byp.rd1",   S_RD1_A,   64'h5555);
        sb_push("byp.busy1", S_BUSY1_A, 64'd0);
`else
        sb_push("byp.rd1",   S_RD1_A,   64'(m_a[2]));
        sb_push("byp.busy1", S_BUSY1_A, 64'd1);
`endif
        #1;
        sb_drain();
        tick();
        bus_a.write_en = 1'b0;
        m_a[2] = 16'h5555;
        mb_a[2] = 1'b0;
        check_ports_a("byp.post", 3'd2, 3'd4);
        bus_a.write_en   = 1'b1;
        bus_a.write_dest = 3'd1;
        bus_a.write_data = 16'h0A0A;
`ifdef GPR_FILE_SB_BYPASS_EN
        sb_push("byp.out", S_OUT_A, 64'h0A0A);
`else
        sb_push("byp.out", S_OUT_A, 64'(m_a[1]));
`endif
        #1;
        sb_drain();
        tick();
        bus_a.write_en = 1'b0;
        m_a[1] = 16'h0A0A;
        check_ports_a("byp.outpost", 3'd1, 3'd2);

        // Mid-operation reset: outputs drop immediately, writes/reserves ignored during clear
        tick();
        bus_a.read_addr_1 = 3'd4;
        bus_a.read_addr_2 = 3'd3;
        rst_n = 1'b0;
        #1;
        sb_push("mid.ready", S_RDY_A,   64'd0);
        sb_push("mid.rd1",   S_RD1_A,   64'd0);
        sb_push("mid.rd2",   S_RD2_A,   64'd0);
        sb_push("mid.busy1", S_BUSY1_A, 64'd0);
        sb_push("mid.out",   S_OUT_A,   64'd0);
        sb_drain();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_a[i] = '0;
        mb_a = '0;
        bus_a.write_en   = 1'b1;
        bus_a.write_dest = 3'd3;
        bus_a.write_data = 16'h7777;
        bus_a.rsv_en     = 1'b1;
        bus_a.rsv_addr   = 3'd5;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 8) begin
                bus_a.write_en = 1'b0;
                bus_a.rsv_en   = 1'b0;
            end
            sb_push($sformatf("mid.rdy%0d", i), S_RDY_A, 64'(i == 8));
            sb_drain();
        end
        for (int i = 0; i < 8; i++) begin
            check_ports_a($sformatf("mid.zero%0d", i), 3'(i), 3'(7 - i));
            tick();
        end

        // Wide instance with ordinary r0
        sb_push("b.rdy", S_RDY_B, 64'd1);
        sb_drain();
        wr_b(4'd0, 32'hDEADBEEF);
        bus_b.read_addr_1 = 4'd0;
        sb_push("b.rd_r0", S_RD1_B, 64'hDEADBEEF);
        #1;
        sb_drain();
        wr_b(4'd15, 32'hCAFEF00D);
        sb_push("b.out", S_OUT_B, 64'hCAFEF00D);
        #1;
        sb_drain();
        wr_b(4'd7, 32'h12345678);
        bus_b.read_addr_1 = 4'd7;
        sb_push("b.rd_r7", S_RD1_B, 64'h12345678);
        sb_push("b.out2",  S_OUT_B, 64'hCAFEF00D);
        #1;
        sb_drain();
        bus_b.rsv_en   = 1'b1;
        bus_b.rsv_addr = 4'd0;
        tick();
        bus_b.rsv_en = 1'b0;
        bus_b.read_addr_1 = 4'd0;
        sb_push("b.busy_r0", S_BUSY1_B, 64'd1);
        sb_push("b.rd_r0b",  S_RD1_B,   64'hDEADBEEF);
        #1;
        sb_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
